// File: rtl/dmem_line_initiator_pkg.sv
// Shared constants for the D-memory line initiator: bus widths, memory timing
// and the FSM state encodings.
package dmem_line_initiator_pkg;

  localparam int unsigned WORD_SIZE_DEF    = 16;
  localparam int unsigned FETCH_SIZE_DEF   = 64;
  localparam int unsigned LINE_LATENCY_DEF = 4;
  localparam int unsigned STORE_HOLD_DEF   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Counter width able to reach the longest wait count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dmem_line_initiator_if.sv
// Request/response handshake between the cache miss/writeback logic (master)
// and the line initiator (slave).
interface dmem_line_initiator_if
  import dmem_line_initiator_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned FETCH_SIZE = FETCH_SIZE_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [WORD_SIZE-1:0]  req_addr;
  logic [FETCH_SIZE-1:0] req_wdata;
  logic                  resp_valid;
  logic [FETCH_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/dmem_line_initiator_bus_driver.sv
// Tri-state driver for the shared line data bus; owns the drive-enable flop so
// the bus is released asynchronously on reset.
module line_bus_driver
  import dmem_line_initiator_pkg::*;
#(
  parameter int unsigned FETCH_SIZE = FETCH_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  drive_set_i,
  input  logic                  drive_clr_i,
  input  logic [FETCH_SIZE-1:0] wdata_i,
  output logic                  drive_en_o,
  inout  wire  [FETCH_SIZE-1:0] d_data
);

  logic drive_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drive_en_q <= 1'b0;
    end else if (drive_set_i) begin
      drive_en_q <= 1'b1;
    end else if (drive_clr_i) begin
      drive_en_q <= 1'b0;
    end
  end

  assign drive_en_o = drive_en_q;
  assign d_data     = drive_en_q ? wdata_i : {FETCH_SIZE{1'bz}};

endmodule

// File: rtl/dmem_line_initiator.sv
// Line initiator for the D-memory port: turns one accepted line fetch/store
// request into a one-cycle strobe, waits out the memory latency, then responds.
module dmem_line_initiator
  import dmem_line_initiator_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter int unsigned FETCH_SIZE   = FETCH_SIZE_DEF,
  parameter int unsigned LINE_LATENCY = LINE_LATENCY_DEF,
  parameter int unsigned STORE_HOLD   = STORE_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dmem_line_initiator_if.slave  req_if,
  output logic                  d_readM,
  output logic                  d_writeM,
  output logic [WORD_SIZE-1:0]  d_address,
  inout  wire  [FETCH_SIZE-1:0] d_data
);

  localparam int unsigned CNT_W = cnt_width(LINE_LATENCY);

  logic [1:0]            state_q,      state_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [WORD_SIZE-1:0]  addr_q,       addr_d;
  logic [FETCH_SIZE-1:0] wdata_q,      wdata_d;
  logic                  wr_q,         wr_d;
  logic                  readM_q,      readM_d;
  logic                  writeM_q,     writeM_d;
  logic                  ready_q,      ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [FETCH_SIZE-1:0] rdata_q,      rdata_d;
  logic                  drive_set;
  logic                  drive_clr;
  logic                  drive_en;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    readM_d      = 1'b0;
    writeM_d     = 1'b0;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    drive_set    = 1'b0;
    drive_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_if.req_valid && ready_q) begin
          addr_d    = {req_if.req_addr[WORD_SIZE-1:2], 2'b00};
          wdata_d   = req_if.req_wdata;
          wr_d      = req_if.req_write;
          readM_d   = ~req_if.req_write;
          writeM_d  = req_if.req_write;
          drive_set = req_if.req_write;
          ready_d   = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wr_q && (cnt_q == CNT_W'(STORE_HOLD))) begin
          drive_clr = 1'b1;
        end
        if (cnt_q == CNT_W'(LINE_LATENCY)) begin
          if (!wr_q) begin
            rdata_d = d_data;
          end
          // Releasing again on exit keeps the bus free even if the hold
          // window were configured longer than the line latency.
          drive_clr    = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      readM_q      <= 1'b0;
      writeM_q     <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      readM_q      <= readM_d;
      writeM_q     <= writeM_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  line_bus_driver #(
    .FETCH_SIZE (FETCH_SIZE)
  ) u_bus_driver (
    .clk         (clk),
    .reset_n     (reset_n),
    .drive_set_i (drive_set),
    .drive_clr_i (drive_clr),
    .wdata_i     (wdata_q),
    .drive_en_o  (drive_en),
    .d_data      (d_data)
  );

  assign req_if.req_ready  = ready_q;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_rdata = rdata_q;
  assign d_readM           = readM_q;
  assign d_writeM          = writeM_q;
  assign d_address         = addr_q;

endmodule

// File: tb/tb_dmem_line_initiator.sv
// Bench for dmem_line_initiator: a timed memory on the far side of the bus,
// a line-level reference model, directed vectors, random traffic and corner cases.
module tb_dmem_line_initiator;
  import dmem_line_initiator_pkg::*;

  localparam int unsigned WS     = 16;
  localparam int unsigned FS     = 64;
  localparam int unsigned LINES  = 1 << (WS - 2);
  localparam int unsigned MEM_RD = 4;
  localparam int unsigned MEM_WR = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          d_readM, d_writeM;
  logic [WS-1:0] d_address;
  wire  [FS-1:0] d_data;

  dmem_line_initiator_if #(.WORD_SIZE(WS), .FETCH_SIZE(FS)) bus ();

  dmem_line_initiator #(
    .WORD_SIZE(WS), .FETCH_SIZE(FS), .LINE_LATENCY(4), .STORE_HOLD(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_if(bus),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] init_line(input int unsigned idx);
    if (idx == 0) return 64'h0000_ffff_0001_9023;
    if (idx == 8) return 64'h6000_0000_0000_0000;
    return {16'(idx), 16'(idx * 3 + 1), 16'(~idx), 16'hc0de};
  endfunction

  // Memory: samples a strobe, returns read data on the 4th edge, commits a store on the 3rd.
  logic [63:0]  mem    [LINES];
  bit           wr_vld [LINES];
  int unsigned  rd_cnt = 0, wr_cnt = 0, wr_idx = 0;
  logic [63:0]  rd_line = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (d_readM) begin
        rd_cnt  <= 1;
        rd_line <= wr_vld[d_address[WS-1:2]] ? mem[d_address[WS-1:2]] : init_line(d_address[WS-1:2]);
      end else if (rd_cnt != 0) begin
        rd_cnt <= (rd_cnt == MEM_RD) ? 0 : rd_cnt + 1;
      end
      if (d_writeM) begin
        wr_cnt <= 1;
        wr_idx <= d_address[WS-1:2];
      end else if (wr_cnt != 0) begin
        if (wr_cnt == MEM_WR) begin
          mem[wr_idx]    <= d_data;
          wr_vld[wr_idx] <= 1'b1;
          wr_cnt         <= 0;
        end else begin
          wr_cnt <= wr_cnt + 1;
        end
      end
    end
  end

  assign d_data = (rd_cnt >= MEM_RD - 1) ? rd_line : {FS{1'bz}};

  // Reference model: a line holds its last completed store, else its initial contents.
  logic [63:0] ref_mem [int unsigned];
  logic [63:0] last_rd = '0;

  function automatic logic [63:0] ref_read(input logic [15:0] addr);
    int unsigned idx = int'(addr >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
  endfunction

  // Accept log and cycle-level protocol monitors.
  int unsigned cyc = 0;
  int unsigned acc_q[$];
  logic        resp_prev = 1'b0;

  always @(posedge clk) begin
    if (reset_n && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      resp_prev = 1'b0;
    end else begin
      check("strobe_exclusive", 64'(d_readM && d_writeM), 64'd0);
      check("drive_on_read", 64'(dut.drive_en && !dut.wr_q), 64'd0);
      check("bus_conflict", 64'(dut.drive_en && (rd_cnt >= MEM_RD - 1)), 64'd0);
      check("resp_pulse", 64'(bus.resp_valid && resp_prev), 64'd0);
      resp_prev = bus.resp_valid;
    end
  end

  // One transaction; results left in t_* for the caller.
  logic [63:0] t_rdata;
  int          t_lat, t_rd, t_wr, t_drive;
  bit          t_timeout, t_addr_ok, t_data_ok, t_ready_ok;

  task automatic wait_ready(input string name);
    int i = 0;
    @(negedge clk);
    while (!bus.req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check({name, "_ready_wait"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic txn(input string name, input logic wr, input logic [15:0] addr, input logic [63:0] wdata);
    wait_ready(name);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    t_lat = 0; t_rd = 0; t_wr = 0; t_drive = 0; t_rdata = '0;
    t_timeout = 1; t_addr_ok = 1; t_data_ok = 1; t_ready_ok = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = {$urandom, $urandom};
      end
      if (d_readM) t_rd++;
      if (d_writeM) t_wr++;
      if (dut.drive_en) begin
        t_drive++;
        if (d_data !== wdata) t_data_ok = 0;
      end
      if (d_address !== {addr[15:2], 2'b00}) t_addr_ok = 0;
      if (bus.req_ready) t_ready_ok = 0;
      if (bus.resp_valid) begin
        t_lat     = k;
        t_rdata   = bus.resp_rdata;
        t_timeout = 0;
        break;
      end
    end
  endtask

  task automatic verify_txn(input string name, input logic wr, input logic [15:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_rdata);
    txn(name, wr, addr, wdata);
    check({name, "_timeout"}, 64'(t_timeout), 64'd0);
    check({name, "_latency"}, 64'(t_lat), 64'd6);
    check({name, "_readM_cycles"}, 64'(t_rd), wr ? 64'd0 : 64'd1);
    check({name, "_writeM_cycles"}, 64'(t_wr), wr ? 64'd1 : 64'd0);
    check({name, "_drive_cycles"}, 64'(t_drive), wr ? 64'd4 : 64'd0);
    check({name, "_drive_data"}, 64'(t_data_ok), 64'd1);
    check({name, "_address"}, 64'(t_addr_ok), 64'd1);
    check({name, "_ready_low"}, 64'(t_ready_ok), 64'd1);
    check({name, "_rdata"}, t_rdata, exp_rdata);
    if (wr) ref_mem[int'(addr >> 2)] = wdata;
    else last_rd = exp_rdata;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b2b_data[2];
    int          b2b_resp, b2b_rd, b2b_wait;
    logic [15:0] a;
    logic        w;
    logic [63:0] d;

    vecs[0] = '{1'b0, 16'h0001, 64'h0, 64'h0000_ffff_0001_9023};
    vecs[1] = '{1'b0, 16'h0023, 64'h0, 64'h6000_0000_0000_0000};
    vecs[2] = '{1'b1, 16'h01f4, 64'h1111_2222_3333_4444, 64'h6000_0000_0000_0000};
    vecs[3] = '{1'b0, 16'h01f6, 64'h0, 64'h1111_2222_3333_4444};
    vecs[4] = '{1'b0, 16'h0003, 64'h0, 64'h0000_ffff_0001_9023};
    vecs[5] = '{1'b1, 16'hffff, 64'ha5a5_0f0f_1234_fedc, 64'h0000_ffff_0001_9023};
    vecs[6] = '{1'b0, 16'hfffc, 64'h0, 64'ha5a5_0f0f_1234_fedc};
    vecs[7] = '{1'b1, 16'h0010, 64'hdead_beef_0bad_f00d, 64'ha5a5_0f0f_1234_fedc};
    vecs[8] = '{1'b0, 16'h0013, 64'h0, 64'hdead_beef_0bad_f00d};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_readM", 64'(d_readM), 64'd0);
    check("rst_writeM", 64'(d_writeM), 64'd0);
    check("rst_address", 64'(d_address), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_drive_en", 64'(dut.drive_en), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      verify_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {14'($urandom_range(16, 31)), 2'($urandom)};
      d = {$urandom, $urandom};
      verify_txn($sformatf("rnd%0d", i), w, a, d, w ? last_rd : ref_read(a));
    end

    // Back-to-back fetches with req_valid held high.
    wait_ready("b2b");
    acc_q.delete();
    b2b_resp = 0; b2b_rd = 0; b2b_wait = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0044;
    while (b2b_resp < 2 && b2b_wait < 40) begin
      @(negedge clk);
      b2b_wait++;
      if (acc_q.size() == 1) bus.req_addr = 16'h0048;
      if (acc_q.size() >= 2) bus.req_valid = 1'b0;
      if (d_readM) b2b_rd++;
      if (bus.resp_valid) begin
        b2b_data[b2b_resp] = bus.resp_rdata;
        b2b_resp++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_resp_count", 64'(b2b_resp), 64'd2);
    check("b2b_accept_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() >= 2) check("b2b_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'd7);
    check("b2b_readM_cycles", 64'(b2b_rd), 64'd2);
    if (b2b_resp == 2) begin
      check("b2b_rdata0", b2b_data[0], ref_read(16'h0044));
      check("b2b_rdata1", b2b_data[1], ref_read(16'h0048));
      last_rd = ref_read(16'h0048);
    end

    // Reset in the middle of a store: bus and strobes released immediately.
    wait_ready("rst_mid");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0100;
    bus.req_wdata = 64'h0123_4567_89ab_cdef;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_drive_before", 64'(dut.drive_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_drive_en", 64'(dut.drive_en), 64'd0);
    check("rst_mid_readM", 64'(d_readM), 64'd0);
    check("rst_mid_writeM", 64'(d_writeM), 64'd0);
    check("rst_mid_rdata", bus.resp_rdata, 64'd0);
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_after", 64'(bus.req_ready), 64'd1);
    check("rst_mid_drive_after", 64'(dut.drive_en), 64'd0);
    verify_txn("post_rst", 1'b0, 16'h0000, 64'h0, 64'h0000_ffff_0001_9023);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
